// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU FSM state
// encoding and small decode helpers used by the load/store unit.
package rv32i_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // LSU control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    // True when funct3 names a real load (write=0) or store (write=1).
    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        logic ok;
        if (write) begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        return ok;
    endfunction

    // True when a halfword is on an odd address or a word is not 4-aligned.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU: byte enables from size and
// address, store data replication, and load lane select with sign/zero
// extension.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unsigned;

    // Pick the addressed byte/halfword out of the read word.
    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half     = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        w_unsigned = (i_funct3 == F3_LBU) || (i_funct3 == F3_LHU);
    end

    // Size decode: lane enables, replicated store data, extended load data.
    // Loads and stores share funct3[1:0] size codes, so one decode serves both.
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'd0;
        o_rdata = 32'd0;
        case (i_funct3)
            F3_LB, F3_LBU: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = w_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            F3_LH, F3_LHU: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = w_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one CPU request at a time, runs a single
// memory transfer with an ack timeout, and returns one response pulse.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word requests are answered with an error and never reach memory.
//
// Handshakes: a CPU request transfers on any cycle with req_valid && req_ready
// (req_ready is high only in IDLE); the memory side holds mem_req and all
// mem_* fields stable until a cycle with mem_ack; resp_valid is a one-cycle
// pulse with no backpressure.
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output lsu_state_t  dbg_state
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    lsu_state_t    r_state;
    lsu_state_t    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [2:0]    r_f3;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_resp_err;
    logic [31:0]   r_resp_rdata;

    logic          w_accept;
    logic          w_misalign;
    logic          w_trap;
    logic          w_timeout;
    logic          w_in_bus;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_rep;
    logic [31:0]   w_rdata_ext;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = f3_misaligned(req_funct3, req_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // Requests that must not reach memory go straight to an error response.
    assign w_trap    = !f3_legal(req_write, req_funct3) || w_misalign;
    assign w_timeout = (r_cnt == CW'(ACK_TIMEOUT - 1));
    assign w_in_bus  = (r_state == ST_BUS);

    lsu_align u_align (
        .i_funct3  (r_f3),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (mem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata_rep),
        .o_rdata   (w_rdata_ext)
    );

    // Next-state decode; the final BUS cycle is either the ack or the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_trap ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                if (mem_ack || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset wins over any request or ack in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch, wait counter and response capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_f3         <= 3'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_we         <= req_write;
                        r_f3         <= req_funct3;
                        r_addr       <= req_addr;
                        r_wdata      <= req_wdata;
                        r_resp_err   <= w_trap;
                        r_resp_rdata <= 32'd0;
                    end
                end
                ST_BUS: begin
                    if (mem_ack) begin
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_we ? 32'd0 : w_rdata_ext;
                    end else if (w_timeout) begin
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Memory fields are only presented during BUS so they read as zero otherwise.
    assign req_ready  = (r_state == ST_IDLE);
    assign mem_req    = w_in_bus;
    assign mem_we     = w_in_bus & r_we;
    assign mem_be     = w_in_bus ? w_be : 4'b0000;
    assign mem_addr   = w_in_bus ? {r_addr[31:2], 2'b00} : 32'd0;
    assign mem_wdata  = w_in_bus ? w_wdata_rep : 32'd0;
    assign resp_valid = (r_state == ST_RESP);
    assign resp_err   = (r_state == ST_RESP) & r_resp_err;
    assign resp_rdata = (r_state == ST_RESP) ? r_resp_rdata : 32'd0;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed vectors for stores,
// signed/unsigned loads, illegal funct3, timeout, misalignment and reset abort.
module tb_load_store_unit;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    lsu_state_t  dbg_state;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.ACK_TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle (accepted at that edge).
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        step();
        req_valid  = 1'b0;
    endtask

    // Acknowledge in the current BUS cycle with the given read data.
    task automatic ack(input logic [31:0] rd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack   = 1'b0;
    endtask

    initial begin
        int n;

        // Reset state
        step();
        step();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        step();

        // SW 0x100, zero-wait ack: resp_valid two cycles after accept
        issue(1'b1, F3_SW, 32'h100, 32'hDEADBEEF);
        chk("sw_mem_req", 32'(mem_req), 32'd1);
        chk("sw_mem_we", 32'(mem_we), 32'd1);
        chk("sw_mem_be", 32'(mem_be), 32'hF);
        chk("sw_mem_addr", mem_addr, 32'h100);
        chk("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_ready_busy", 32'(req_ready), 32'd0);
        chk("sw_no_early_resp", 32'(resp_valid), 32'd0);
        ack(32'h0);
        chk("sw_resp_valid", 32'(resp_valid), 32'd1);
        chk("sw_resp_err", 32'(resp_err), 32'd0);
        chk("sw_resp_rdata", resp_rdata, 32'd0);
        chk("sw_mem_req_drop", 32'(mem_req), 32'd0);
        step();
        chk("sw_resp_one_cycle", 32'(resp_valid), 32'd0);
        chk("sw_ready_again", 32'(req_ready), 32'd1);

        // LB 0x103: top lane 0x80 sign-extends
        issue(1'b0, F3_LB, 32'h103, 32'h0);
        chk("lb_mem_be", 32'(mem_be), 32'h8);
        chk("lb_mem_we", 32'(mem_we), 32'd0);
        chk("lb_mem_addr", mem_addr, 32'h100);
        ack(32'h80112233);
        chk("lb_resp_valid", 32'(resp_valid), 32'd1);
        chk("lb_resp_rdata", resp_rdata, 32'hFFFFFF80);
        step();

        // LBU 0x103: zero-extends
        issue(1'b0, F3_LBU, 32'h103, 32'h0);
        ack(32'h80112233);
        chk("lbu_resp_rdata", resp_rdata, 32'h00000080);
        step();

        // SH 0x102: upper lanes, halfword replicated
        issue(1'b1, F3_SH, 32'h102, 32'h0000ABCD);
        chk("sh_mem_be", 32'(mem_be), 32'hC);
        chk("sh_mem_wdata", mem_wdata, 32'hABCDABCD);
        ack(32'h12345678);
        chk("sh_resp_rdata", resp_rdata, 32'd0);
        step();

        // SB 0x101: lane 1, byte replicated
        issue(1'b1, F3_SB, 32'h101, 32'h0000005A);
        chk("sb_mem_be", 32'(mem_be), 32'h2);
        chk("sb_mem_wdata", mem_wdata, 32'h5A5A5A5A);
        ack(32'h0);
        step();

        // LH 0x102 with two wait cycles: fields held, response delayed
        issue(1'b0, F3_LH, 32'h102, 32'h0);
        chk("lh_mem_be", 32'(mem_be), 32'hC);
        step();
        chk("lh_wait1_req", 32'(mem_req), 32'd1);
        chk("lh_wait1_be", 32'(mem_be), 32'hC);
        step();
        chk("lh_wait2_no_resp", 32'(resp_valid), 32'd0);
        chk("lh_wait2_addr", mem_addr, 32'h100);
        ack(32'h80011234);
        chk("lh_resp_valid", 32'(resp_valid), 32'd1);
        chk("lh_resp_rdata", resp_rdata, 32'hFFFF8001);
        step();

        // LHU 0x100: lower lanes, zero-extended
        issue(1'b0, F3_LHU, 32'h100, 32'h0);
        chk("lhu_mem_be", 32'(mem_be), 32'h3);
        ack(32'h1234F00D);
        chk("lhu_resp_rdata", resp_rdata, 32'h0000F00D);
        step();

        // Illegal load funct3 3: straight to an error response, no bus access
        issue(1'b0, 3'd3, 32'h100, 32'h0);
        chk("ill_ld_mem_req", 32'(mem_req), 32'd0);
        chk("ill_ld_resp_valid", 32'(resp_valid), 32'd1);
        chk("ill_ld_resp_err", 32'(resp_err), 32'd1);
        step();

        // Illegal store funct3 4
        issue(1'b1, 3'd4, 32'h100, 32'h11111111);
        chk("ill_st_mem_req", 32'(mem_req), 32'd0);
        chk("ill_st_resp_err", 32'(resp_err), 32'd1);
        step();

        // Ack while IDLE is ignored
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("idle_ack_no_resp", 32'(resp_valid), 32'd0);

        // LW with no ack: error after 16 BUS cycles
        issue(1'b0, F3_LW, 32'h200, 32'h0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) break;
            if (mem_req) n++;
            step();
        end
        chk("to_bus_cycles", 32'(n), 32'd16);
        chk("to_resp_valid", 32'(resp_valid), 32'd1);
        chk("to_resp_err", 32'(resp_err), 32'd1);
        chk("to_resp_rdata", resp_rdata, 32'd0);
        chk("to_mem_req_low", 32'(mem_req), 32'd0);
        step();
        chk("to_idle", 32'(dbg_state), 32'(ST_IDLE));

        // LW at 0x101
        issue(1'b0, F3_LW, 32'h101, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_mem_req", 32'(mem_req), 32'd0);
        chk("mis_resp_valid", 32'(resp_valid), 32'd1);
        chk("mis_resp_err", 32'(resp_err), 32'd1);
        step();
`else
        chk("mis_mem_req", 32'(mem_req), 32'd1);
        chk("mis_mem_addr", mem_addr, 32'h100);
        chk("mis_mem_be", 32'(mem_be), 32'hF);
        ack(32'h11223344);
        chk("mis_resp_err", 32'(resp_err), 32'd0);
        chk("mis_resp_rdata", resp_rdata, 32'h11223344);
        step();
`endif

        // Reset in the 3rd BUS cycle, with a request pending, then a late ack
        issue(1'b0, F3_LW, 32'h300, 32'h0);
        step();
        step();
        chk("rab_bus3_req", 32'(mem_req), 32'd1);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_funct3 = F3_LW;
        req_addr  = 32'h400;
        step();
        chk("rab_mem_req_drop", 32'(mem_req), 32'd0);
        chk("rab_state_rst", 32'(dbg_state), 32'(ST_IDLE));
        chk("rab_no_resp_rst", 32'(resp_valid), 32'd0);
        reset     = 1'b0;
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        step();
        mem_ack = 1'b0;
        chk("rab_late_ack_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rab_ready", 32'(req_ready), 32'd1);
        chk("rab_no_mem_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("rab_no_resp", 32'(resp_valid), 32'd0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16, meaning the maximum number of BUS cycles waited for mem_ack before an error response.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have CPU request ports, all inputs: req_valid 1, req_write 1, req_funct3 3, req_addr 32, req_wdata 32.
REQ-005 SHALL have req_ready, output, 1 bit: request accepted on a cycle with req_valid && req_ready.
REQ-006 SHALL have CPU response ports, all outputs: resp_valid 1, resp_rdata 32, resp_err 1.
REQ-007 SHALL have memory ports, all outputs: mem_req 1, mem_we 1, mem_be 4, mem_addr 32 (bits [1:0] always 0), mem_wdata 32.
REQ-008 SHALL have memory inputs: mem_ack 1, mem_rdata 32.

Function
REQ-009 SHALL implement FSM states IDLE, BUS, RESP; req_ready=1 only in IDLE.
REQ-010 IDLE + accept of a legal request SHALL latch all request fields and go to BUS; mem_req asserts on the next cycle.
REQ-011 BUS SHALL hold mem_req=1 and mem_we/mem_be/mem_addr/mem_wdata stable until mem_ack or timeout.
REQ-012 BUS + mem_ack SHALL capture the extracted load data and go to RESP; mem_req drops in the cycle after ack.
REQ-013 BUS SHALL count cycles without ack; count reaching ACK_TIMEOUT SHALL go to RESP with resp_err=1 and resp_rdata=0.
REQ-014 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE.
REQ-015 Latency: accept at cycle N, zero-wait ack at N+1, resp_valid at N+2; each wait cycle adds one.
REQ-016 Legal loads: funct3 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Legal stores: 0 SB, 1 SH, 2 SW.
REQ-017 Any other funct3 SHALL skip BUS and go IDLE->RESP with resp_err=1 and no mem_req.
REQ-018 Stores: SB SHALL set mem_be=1<<addr[1:0] with the byte replicated x4; SH SHALL set be 0011/1100 from addr[1] with the halfword replicated x2; SW SHALL set be 1111.
REQ-019 Loads SHALL drive mem_be per the same lane rule, select the addressed lane(s), and sign-extend (LB/LH) or zero-extend (LBU/LHU).
REQ-020 Store responses SHALL return resp_rdata=0.
REQ-021 mem_ack outside BUS SHALL be ignored.
REQ-022 mem_addr SHALL equal {req_addr[31:2],2'b00}.

Reset
REQ-023 Reset SHALL force IDLE, clear the timeout counter, and set resp_valid, resp_err, mem_req, mem_we to 0, mem_be to 0000, and resp_rdata, mem_addr, mem_wdata to 0.
REQ-024 Reset asserted during BUS SHALL drop mem_req at that edge; no response is ever issued for the aborted request.
REQ-025 Reset SHALL take priority over a simultaneous mem_ack or req_valid.

Configuration
REQ-026 With macro LSU_MISALIGN_TRAP_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL go IDLE->RESP with resp_err=1 and no mem_req.
REQ-027 Without LSU_MISALIGN_TRAP_EN, the misaligned low address bits SHALL be ignored (halfword uses addr[1], word uses lanes 1111) and no error is raised.

Structure
REQ-028 Shared package rv32i_pkg SHALL hold the funct3 load/store constants and the LSU state encoding.
REQ-029 Lane steering and extension SHALL be a combinational sub-module lsu_align; the FSM and counter stay in load_store_unit.

Verification
REQ-030 SW addr 0x100 wdata 0xDEADBEEF, ack after 0 waits -> mem_be=1111, mem_addr=0x100, resp_valid two cycles after accept, resp_err=0.
REQ-031 LB addr 0x103, mem_rdata 0x80112233 -> resp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 SH addr 0x102 wdata 0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD.
REQ-033 LW with mem_ack never asserted, ACK_TIMEOUT=16 -> resp_err=1 after 16 BUS cycles, mem_req low afterwards.
REQ-034 LW addr 0x101 -> with macro: resp_err=1, no mem_req; without macro: mem_addr=0x100, resp_err=0.
REQ-035 Reset asserted in the 3rd BUS cycle, late mem_ack delivered -> no resp_valid, FSM in IDLE, req_ready=1.
